// File: rtl/qerv_pkg.sv
// Shared immediate-decoder definitions: format encodings and the legal beat-width check.
package qerv_pkg;

  localparam logic [2:0] IMM_FMT_I = 3'd0;
  localparam logic [2:0] IMM_FMT_S = 3'd1;
  localparam logic [2:0] IMM_FMT_B = 3'd2;
  localparam logic [2:0] IMM_FMT_U = 3'd3;
  localparam logic [2:0] IMM_FMT_J = 3'd4;
  localparam logic [2:0] IMM_FMT_Z = 3'd5;

  function automatic bit w_is_legal(input int unsigned w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8);
  endfunction

endpackage

// File: rtl/qerv_immdec_fmt.sv
// Combinational image builder: expands the instruction word into a 32-bit immediate.
// Format Z (CSR zimm) is only decoded when QERV_IMMDEC_CSR_EN is defined.
module qerv_immdec_fmt
  import qerv_pkg::*;
(
  input  logic [31:7] i_wb_rdt,
  input  logic [2:0]  i_fmt,
  output logic [31:0] o_image
);

  always_comb begin
    o_image = '0;
    case (i_fmt)
      IMM_FMT_I: o_image = {{21{i_wb_rdt[31]}}, i_wb_rdt[30:20]};
      IMM_FMT_S: o_image = {{21{i_wb_rdt[31]}}, i_wb_rdt[30:25], i_wb_rdt[11:7]};
      IMM_FMT_B: o_image = {{20{i_wb_rdt[31]}}, i_wb_rdt[7], i_wb_rdt[30:25],
                            i_wb_rdt[11:8], 1'b0};
      IMM_FMT_U: o_image = {i_wb_rdt[31:12], 12'b0};
      IMM_FMT_J: o_image = {{12{i_wb_rdt[31]}}, i_wb_rdt[19:12], i_wb_rdt[20],
                            i_wb_rdt[30:21], 1'b0};
`ifdef QERV_IMMDEC_CSR_EN
      IMM_FMT_Z: o_image = {27'b0, i_wb_rdt[19:15]};
`endif
      default:   o_image = '0;
    endcase
  end

endmodule

// File: rtl/qerv_immdec_par.sv
// Immediate decoder that captures an instruction and streams its immediate W bits per beat, LSB-first.
// Optional CSR zimm support is enabled by defining QERV_IMMDEC_CSR_EN.
module qerv_immdec_par
  import qerv_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wb_en,
  input  logic [31:7]   i_wb_rdt,
  input  logic [2:0]    i_imm_fmt,
  input  logic          i_cnt_en,
  output logic [W-1:0]  o_imm,
  output logic          o_imm_last,
  output logic [4:0]    o_rd_addr,
  output logic [4:0]    o_rs1_addr,
  output logic [4:0]    o_rs2_addr,
  output logic [4:0]    o_csr_imm
);

  localparam int unsigned B  = 32 / W;
  localparam int unsigned CW = (B > 1) ? $clog2(B) : 1;

  if (!w_is_legal(W)) begin : g_bad_w
    $error("qerv_immdec_par: W must be 1, 2, 4 or 8");
  end

  logic [31:0]   image;
  logic [31:0]   image_load;
  logic [CW-1:0] cnt;
  logic          cnt_max;

  qerv_immdec_fmt u_fmt (
    .i_wb_rdt (i_wb_rdt),
    .i_fmt    (i_imm_fmt),
    .o_image  (image_load)
  );

  assign cnt_max    = (cnt == CW'(B - 1));
  assign o_imm      = image[W-1:0];
  assign o_imm_last = cnt_max;

  // Capture has priority over shifting; shifting replicates the sign into the vacated top bits.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      image      <= '0;
      cnt        <= '0;
      o_rd_addr  <= '0;
      o_rs1_addr <= '0;
      o_rs2_addr <= '0;
    end else if (i_wb_en) begin
      image      <= image_load;
      cnt        <= '0;
      o_rd_addr  <= i_wb_rdt[11:7];
      o_rs1_addr <= i_wb_rdt[19:15];
      o_rs2_addr <= i_wb_rdt[24:20];
    end else if (i_cnt_en) begin
      image <= {{W{image[31]}}, image[31:W]};
      cnt   <= cnt_max ? '0 : cnt + CW'(1);
    end
  end

`ifdef QERV_IMMDEC_CSR_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_csr_imm <= '0;
    end else if (i_wb_en) begin
      o_csr_imm <= i_wb_rdt[19:15];
    end
  end
`else
  assign o_csr_imm = '0;
`endif

endmodule

// File: doc/qerv_immdec_par.md
QERV_IMMDEC_PAR -- requirements
Module: qerv_immdec_par

Interface
REQ-001 The module SHALL have parameter W, default 4, giving immediate bits emitted per shift beat; legal values are 1, 2, 4 and 8.
REQ-002 The module SHALL have port i_clk, input, 1 bit, the single clock.
REQ-003 The module SHALL have port i_rst_n, input, 1 bit, a synchronous active-low reset.
REQ-004 The module SHALL have port i_wb_en, input, 1 bit, an instruction capture strobe.
REQ-005 The module SHALL have port i_wb_rdt, input, 25 bits [31:7], the instruction word.
REQ-006 The module SHALL have port i_imm_fmt, input, 3 bits, the format selector, sampled with i_wb_en.
REQ-007 The module SHALL have port i_cnt_en, input, 1 bit, a shift-one-beat request.
REQ-008 The module SHALL have port o_imm, output, W bits, the current immediate beat, LSB-first.
REQ-009 The module SHALL have port o_imm_last, output, 1 bit, high while the final beat is presented.
REQ-010 The module SHALL have ports o_rd_addr, o_rs1_addr and o_rs2_addr, outputs, 5 bits each, the register addresses.
REQ-011 The module SHALL have port o_csr_imm, output, 5 bits, the CSR zimm field.

Function
REQ-012 The beat count SHALL be B = 32/W, tracked by a beat counter of max(1, clog2(B)) bits.
REQ-013 When i_wb_en is high, the block SHALL, on the next edge, load a 32-bit immediate image per i_imm_fmt (0 I, 1 S, 2 B, 3 U, 4 J, 5 Z = zero-extended bits 19:15, 6-7 all-zero), latch the addresses from bits 11:7, 19:15 and 24:20, latch o_csr_imm from bits 19:15, and clear the beat counter.
REQ-014 For formats I, S, B, U and J, the image SHALL be sign-extended from instruction bit 31 per the RISC-V base encoding.
REQ-015 o_imm SHALL equal image bits [W-1:0] combinationally from registered state, with zero cycles of latency after capture.
REQ-016 On i_cnt_en, the image SHALL shift right by W bits, with the top W bits refilled with the sign bit, and the counter SHALL increment.
REQ-017 o_imm_last SHALL be high when the counter equals B-1.
REQ-018 i_cnt_en while o_imm_last is high SHALL wrap the counter to 0.
REQ-019 After the wrap, o_imm SHALL continue to present sign fill.
REQ-020 When i_wb_en and i_cnt_en are high in the same cycle, capture SHALL win and no shift SHALL occur.
REQ-021 i_cnt_en with no prior capture SHALL shift the reset image, emitting zero.
REQ-022 Register address outputs SHALL change only on capture or reset.

Reset
REQ-023 When i_rst_n is low at a clock edge, the block SHALL set the image, counter, o_imm, o_imm_last, all addresses and o_csr_imm to 0.
REQ-024 Reset SHALL take priority over i_wb_en and i_cnt_en.
REQ-025 Reset asserted mid-sequence SHALL abandon the sequence, and the next capture SHALL start cleanly at beat 0.

Configuration
REQ-026 With QERV_IMMDEC_CSR_EN defined, format 5 and o_csr_imm SHALL be implemented as in REQ-013.
REQ-027 With QERV_IMMDEC_CSR_EN undefined, format 5 SHALL decode as all-zero, o_csr_imm SHALL be tied to 0, and no zimm flops SHALL exist.

Structure
REQ-028 The shared package qerv_pkg SHALL hold the format encoding constants (IMM_FMT_I/S/B/U/J/Z) and the legal-W check helper.
REQ-029 The image builder SHALL be a combinational sub-module named qerv_immdec_fmt, taking i_wb_rdt and the format and producing the 32-bit image.
REQ-030 Sequential logic SHALL reside only in qerv_immdec_par.
REQ-031 An illegal W SHALL fail elaboration.

Verification
REQ-032 The bench SHALL check: W=4, capture 0xFFF00093 fmt I, then 8 i_cnt_en -> o_imm=0xF every beat, o_imm_last on the 8th beat, o_rd_addr=1, o_rs1_addr=0.
REQ-033 The bench SHALL check: W=4, capture 0x12345037 fmt U -> beats 0,0,0,5,4,3,2,1, and o_rd_addr=0.
REQ-034 The bench SHALL check: W=8, capture 0x0020A423 fmt S -> beats 0x08,0x00,0x00,0x00, o_rs1_addr=1, o_rs2_addr=2, with o_imm_last on the 4th beat.
REQ-035 The bench SHALL check: W=1, capture 0xFFDFF06F fmt J -> serial bits 0,0,1,1,...,1 (value 0xFFFFFFFC) over 32 beats, then sign fill 1 after the wrap.
REQ-036 The bench SHALL check: W=4, capture 0xFFF00093 fmt I, shift 3 beats, drive i_rst_n low for 1 cycle -> all outputs 0 and counter 0; then capture 0x12345037 fmt U -> first beat 0 with o_imm_last low.
REQ-037 The bench SHALL check: W=4, simultaneous i_wb_en and i_cnt_en -> image loaded unshifted with counter 0; and with QERV_IMMDEC_CSR_EN, capture 0x000FD073 fmt Z -> o_csr_imm=0x1F and beats F,1,0,...
